// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet encoder.
// Provides the flit geometry, the flit-type codes, the field positions
// inside a flit, the encoder FSM state encoding and the tail checksum.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int NUM_FLITS = 6;

  // Every flit splits into a 2-bit type field and a 14-bit payload field.
  localparam int TYPE_MSB  = 15;
  localparam int TYPE_LSB  = 14;
  localparam int PAYLOAD_W = 14;

  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  // Positions of the packet flits inside the flit bank.
  localparam int IDX_HEAD  = 0;
  localparam int IDX_BODY1 = 1;
  localparam int IDX_BODY2 = 2;
  localparam int IDX_BODY3 = 3;
  localparam int IDX_BODY4 = 4;
  localparam int IDX_TAIL  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_SEND   = 2'd2
  } enc_state_e;

  // Tail checksum: XOR of the payload fields of head and body1..4.
  function automatic logic [PAYLOAD_W-1:0] flit_csum(
    input logic [FLIT_W-1:0] head,
    input logic [FLIT_W-1:0] body1,
    input logic [FLIT_W-1:0] body2,
    input logic [FLIT_W-1:0] body3,
    input logic [FLIT_W-1:0] body4
  );
    return head[PAYLOAD_W-1:0] ^ body1[PAYLOAD_W-1:0] ^ body2[PAYLOAD_W-1:0]
         ^ body3[PAYLOAD_W-1:0] ^ body4[PAYLOAD_W-1:0];
  endfunction

endpackage

// File: rtl/noc_flit_serializer.sv
// Serial flit stream over a bank of packet flits.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start         pulse: a freshly built bank is ready, begin at flit 0
//   i_bank          flit bank, entry 0 is sent first
//   i_flit_ready    sink accepts the current flit
//   o_flit          current flit (zero while not valid)
//   o_flit_valid    current flit is valid
//   o_done          last flit is being accepted this cycle
module noc_flit_serializer #(
  parameter int NUM_FLITS = 6,
  parameter int FLIT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic [NUM_FLITS-1:0][FLIT_W-1:0] i_bank,
  input  logic                             i_flit_ready,
  output logic [FLIT_W-1:0]                o_flit,
  output logic                             o_flit_valid,
  output logic                             o_done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_FLITS - 1);

  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       accept;

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    accept  = valid_q && i_flit_ready;
    o_done  = accept && (idx_q == LAST_IDX);
    if (i_start) begin
      idx_d   = 3'd0;
      valid_d = 1'b1;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = 3'd0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // The output mux only depends on registered state, so i_flit_ready
  // never reaches o_flit or o_flit_valid combinationally.
  always_comb begin
    o_flit = '0;
    for (int i = 0; i < NUM_FLITS; i++) begin
      if (valid_q && (idx_q == 3'(i))) begin
        o_flit = i_bank[i];
      end
    end
  end

  assign o_flit_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/noc_packet_encoder.sv
// Turns a memory request into a six-flit NoC write packet.
// The packet is presented both as a parallel flit bundle (qualified by a
// one-cycle o_en strobe) and as a serial valid/ready flit stream.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_valid / o_ready               request handshake
//   i_address, i_rw, i_wdata, i_dest request fields
//   o_head_flit .. o_tail_flit      parallel flits, held until next encode
//   o_en                            one-cycle strobe, parallel flits valid
//   o_flit, o_flit_valid, i_flit_ready  serial flit stream
//   o_busy                          packet in flight
module noc_packet_encoder #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 6,
  parameter int NUM_FLITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_rw,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DEST_WIDTH-1:0] i_dest,
  output logic [15:0]           o_head_flit,
  output logic [15:0]           o_body_flit_1,
  output logic [15:0]           o_body_flit_2,
  output logic [15:0]           o_body_flit_3,
  output logic [15:0]           o_body_flit_4,
  output logic [15:0]           o_tail_flit,
  output logic                  o_en,
  output logic [15:0]           o_flit,
  output logic                  o_flit_valid,
  input  logic                  i_flit_ready,
  output logic                  o_busy
);

  import noc_pkg::*;

  enc_state_e state_q, state_d;
  logic       ready_q, ready_d;
  logic       en_q, en_d;

  // Request captured at acceptance so later input changes cannot leak in.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;

  logic [NUM_FLITS-1:0][FLIT_W-1:0] bank_q, bank_d;

  logic [FLIT_W-1:0] head_w, body1_w, body2_w, body3_w, body4_w, tail_w;
  logic              ser_done;

  always_comb begin
    head_w                     = '0;
    head_w[TYPE_MSB:TYPE_LSB]  = FLIT_HEAD;
    head_w[DEST_WIDTH-1:0]     = dest_q;
    body1_w = {addr_q[PAYLOAD_W-1:0], rw_q, 1'b0};
    body2_w = {wdata_q[31:17], 1'b0};
    body3_w = {wdata_q[16:2], 1'b0};
    body4_w = {wdata_q[1:0], 14'b0};
    tail_w  = {FLIT_TAIL, flit_csum(head_w, body1_w, body2_w, body3_w, body4_w)};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    dest_d  = dest_q;
    bank_d  = bank_q;
    en_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          addr_d  = i_address;
          rw_d    = i_rw;
          wdata_d = i_wdata;
          dest_d  = i_dest;
          state_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        bank_d[IDX_HEAD]  = head_w;
        bank_d[IDX_BODY1] = body1_w;
        bank_d[IDX_BODY2] = body2_w;
        bank_d[IDX_BODY3] = body3_w;
        bank_d[IDX_BODY4] = body4_w;
        bank_d[IDX_TAIL]  = tail_w;
        en_d              = 1'b1;
        state_d           = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready follows the next state, so it rises one cycle after reset
    // release and is dropped on the accepting edge.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      dest_q  <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      dest_q  <= dest_d;
      bank_q  <= bank_d;
    end
  end

  noc_flit_serializer #(
    .NUM_FLITS (NUM_FLITS),
    .FLIT_W    (FLIT_W)
  ) u_serializer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (state_q == ST_ENCODE),
    .i_bank       (bank_q),
    .i_flit_ready (i_flit_ready),
    .o_flit       (o_flit),
    .o_flit_valid (o_flit_valid),
    .o_done       (ser_done)
  );

  assign o_ready       = ready_q;
  assign o_en          = en_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_head_flit   = bank_q[IDX_HEAD];
  assign o_body_flit_1 = bank_q[IDX_BODY1];
  assign o_body_flit_2 = bank_q[IDX_BODY2];
  assign o_body_flit_3 = bank_q[IDX_BODY3];
  assign o_body_flit_4 = bank_q[IDX_BODY4];
  assign o_tail_flit   = bank_q[IDX_TAIL];

endmodule

// File: tb/tb_noc_packet_encoder.sv
// Bench for noc_packet_encoder: directed and randomized requests checked
// against an arithmetic model of the packet format.
module tb_noc_packet_encoder;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [13:0] i_address;
  logic        i_rw;
  logic [31:0] i_wdata;
  logic [5:0]  i_dest;
  logic [15:0] o_head_flit, o_body_flit_1, o_body_flit_2;
  logic [15:0] o_body_flit_3, o_body_flit_4, o_tail_flit;
  logic        o_en;
  logic [15:0] o_flit;
  logic        o_flit_valid;
  logic        i_flit_ready;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] par   [6];
  logic [15:0] exp_f [6];
  logic [15:0] exp_a [6];
  logic [15:0] exp_b [6];

  noc_packet_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_address     (i_address),
    .i_rw          (i_rw),
    .i_wdata       (i_wdata),
    .i_dest        (i_dest),
    .o_head_flit   (o_head_flit),
    .o_body_flit_1 (o_body_flit_1),
    .o_body_flit_2 (o_body_flit_2),
    .o_body_flit_3 (o_body_flit_3),
    .o_body_flit_4 (o_body_flit_4),
    .o_tail_flit   (o_tail_flit),
    .o_en          (o_en),
    .o_flit        (o_flit),
    .o_flit_valid  (o_flit_valid),
    .i_flit_ready  (i_flit_ready),
    .o_busy        (o_busy)
  );

  assign par[0] = o_head_flit;
  assign par[1] = o_body_flit_1;
  assign par[2] = o_body_flit_2;
  assign par[3] = o_body_flit_3;
  assign par[4] = o_body_flit_4;
  assign par[5] = o_tail_flit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet format computed with plain integer arithmetic.
  task automatic model(input int unsigned a, input int unsigned rw,
                       input int unsigned d, input int unsigned dst);
    int unsigned cs;
    exp_f[0] = 16'(32'h8000 | dst);
    exp_f[1] = 16'((a << 2) | (rw << 1));
    exp_f[2] = 16'((d >> 17) * 2);
    exp_f[3] = 16'(((d >> 2) % 32768) * 2);
    exp_f[4] = 16'((d % 4) * 16384);
    cs = 0;
    for (int i = 0; i < 5; i++) cs = cs ^ (32'(exp_f[i]) & 32'h3FFF);
    exp_f[5] = 16'(32'hC000 | cs);
  endtask

  task automatic scramble();
    i_address = 14'($urandom);
    i_rw      = 1'($urandom);
    i_wdata   = $urandom;
    i_dest    = 6'($urandom);
  endtask

  // mode 0: sink always ready; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_packet(input logic [13:0] a, input logic rw, input logic [31:0] d,
                            input logic [5:0] dst, input int mode);
    int   guard;
    int   k;
    int   cyc;
    logic rdy;
    logic stalled;
    logic [15:0] prev;
    model(a, rw, d, dst);
    i_address = a; i_rw = rw; i_wdata = d; i_dest = dst;
    i_valid = 1'b1;
    guard = 0;
    while (!o_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!o_ready) begin
      check("ready_wait", 32'(o_ready), 32'd1);
      i_valid = 1'b0;
      return;
    end
    tick();
    i_valid = 1'b0;
    scramble();
    check("encode_ready", 32'(o_ready), 32'd0);
    check("encode_en", 32'(o_en), 32'd0);
    check("encode_vld", 32'(o_flit_valid), 32'd0);
    check("encode_busy", 32'(o_busy), 32'd1);
    tick();
    check("en_pulse", 32'(o_en), 32'd1);
    for (int i = 0; i < 6; i++) check($sformatf("par%0d", i), 32'(par[i]), 32'(exp_f[i]));
    k = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (k < 6 && cyc < 60) begin
      if (cyc > 0) check("en_once", 32'(o_en), 32'd0);
      check("ser_vld", 32'(o_flit_valid), 32'd1);
      if (stalled) check("ser_hold", 32'(o_flit), 32'(prev));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      i_flit_ready = rdy;
      if (rdy) begin
        check($sformatf("ser_flit%0d", k), 32'(o_flit), 32'(exp_f[k]));
        k++;
        stalled = 1'b0;
      end else begin
        prev    = o_flit;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    if (k < 6) check("ser_timeout", 32'(k), 32'd6);
    i_flit_ready = 1'b0;
    check("end_vld", 32'(o_flit_valid), 32'd0);
    check("end_busy", 32'(o_busy), 32'd0);
    check("end_ready", 32'(o_ready), 32'd1);
    check("par_hold_tail", 32'(o_tail_flit), 32'(exp_f[5]));
  endtask

  initial begin
    int guard;
    int npk;
    int acc;
    int cyc;
    int en_cyc [2];
    logic accept_now;

    rst_n = 1'b0; i_valid = 1'b0; i_flit_ready = 1'b0;
    i_address = '0; i_rw = 1'b0; i_wdata = '0; i_dest = '0;
    en_cyc[0] = 0; en_cyc[1] = 0;

    // Reset state and ready timing after release
    tick(); tick();
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_en", 32'(o_en), 32'd0);
    check("rst_vld", 32'(o_flit_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_flit", 32'(o_flit), 32'd0);
    for (int i = 0; i < 6; i++) check($sformatf("rst_par%0d", i), 32'(par[i]), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready0", 32'(o_ready), 32'd0);
    tick();
    check("rel_ready1", 32'(o_ready), 32'd1);

    // Directed reference packet, sink always ready
    run_packet(14'h1ABC, 1'b1, 32'hDEADBEEF, 6'h05, 0);
    check("ref_head", 32'(o_head_flit), 32'h8005);
    check("ref_tail", 32'(o_tail_flit), 32'hEB2D);

    // Same packet with a stalling sink
    run_packet(14'h1ABC, 1'b1, 32'hDEADBEEF, 6'h05, 1);

    // All-zero request
    run_packet(14'h0, 1'b0, 32'h0, 6'h0, 0);
    check("zero_body1", 32'(o_body_flit_1), 32'h0000);
    check("zero_tail", 32'(o_tail_flit), 32'hC000);

    // Back-to-back requests, i_valid held, inputs switch during packet A
    model(32'h0123, 1, 32'h13579BDF, 6'h2A);
    for (int i = 0; i < 6; i++) exp_a[i] = exp_f[i];
    model(32'h3F0F, 0, 32'hA5A55A5A, 6'h11);
    for (int i = 0; i < 6; i++) exp_b[i] = exp_f[i];
    i_address = 14'h0123; i_rw = 1'b1; i_wdata = 32'h13579BDF; i_dest = 6'h2A;
    i_valid = 1'b1; i_flit_ready = 1'b1;
    npk = 0; acc = 0; cyc = 0;
    while (cyc < 40 && npk < 2) begin
      if (o_en) begin
        en_cyc[npk] = cyc;
        for (int i = 0; i < 6; i++)
          check($sformatf("b2b_p%0d_par%0d", npk, i), 32'(par[i]),
                32'(npk == 0 ? exp_a[i] : exp_b[i]));
        npk++;
      end
      accept_now = o_ready && i_valid;
      tick();
      cyc++;
      if (accept_now) begin
        acc++;
        if (acc == 1) begin
          i_address = 14'h3F0F; i_rw = 1'b0; i_wdata = 32'hA5A55A5A; i_dest = 6'h11;
        end else begin
          i_valid = 1'b0;
          scramble();
        end
      end
    end
    check("b2b_count", 32'(npk), 32'd2);
    check("b2b_spacing", 32'(en_cyc[1] - en_cyc[0]), 32'd8);
    guard = 0;
    while (o_busy && guard < 20) begin
      tick();
      guard++;
    end
    check("b2b_drain", 32'(o_busy), 32'd0);
    i_flit_ready = 1'b0;
    tick();

    // Reset while the serializer is on flit 3
    model(32'h2468, 1, 32'hCAFEF00D, 6'h3C);
    i_address = 14'h2468; i_rw = 1'b1; i_wdata = 32'hCAFEF00D; i_dest = 6'h3C;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    i_flit_ready = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_vld", 32'(o_flit_valid), 32'd1);
    check("pre_rst_idx3", 32'(o_flit), 32'(exp_f[3]));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(o_flit_valid), 32'd0);
    check("mid_rst_flit", 32'(o_flit), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_head", 32'(o_head_flit), 32'd0);
    check("mid_rst_tail", 32'(o_tail_flit), 32'd0);
    i_flit_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_vld", 32'(o_flit_valid), 32'd0);
    run_packet(14'h0A5F, 1'b0, 32'h89ABCDEF, 6'h21, 0);

    // Randomized requests with random sink back-pressure
    for (int n = 0; n < 25; n++) begin
      run_packet(14'($urandom), 1'($urandom), $urandom, 6'($urandom), (n % 3 == 0) ? 0 : 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
